// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM encoding, parity types and
// the prescale values the receiver is built to handle.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    localparam int DATA_WIDTH_DEF = 8;

endpackage

// File: rtl/uart_rx_data_sampler.sv
// Mid-bit 3-sample majority voter. It captures RX_IN at P/2-1, P/2 and
// P/2+1 and presents the majority once all three samples are in.
module rx_data_sampler #(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      sampled_bit,
    output logic                      sample_valid
);

    localparam logic [PRESCALE_WIDTH-1:0] ONE = PRESCALE_WIDTH'(1);
    localparam logic [PRESCALE_WIDTH-1:0] TWO = PRESCALE_WIDTH'(2);

    logic [PRESCALE_WIDTH-1:0] half;
    logic [2:0]                samples;

    assign half = prescale >> 1;

    // capture the three samples around the middle of the bit
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            samples <= '0;
        end else begin
            if (edge_cnt == half - ONE) samples[0] <= RX_IN;
            if (edge_cnt == half)       samples[1] <= RX_IN;
            if (edge_cnt == half + ONE) samples[2] <= RX_IN;
        end
    end

    assign sampled_bit  = (samples[0] & samples[1]) |
                          (samples[0] & samples[2]) |
                          (samples[1] & samples[2]);
    assign sample_valid = (edge_cnt >= half + TWO);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start detect, 8 data bits LSB first, optional parity and
// one stop bit. Good bytes are presented with a one-cycle Data_Valid strobe;
// parity and stop failures get their own one-cycle strobes instead.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      Data_Valid,
    output logic                      par_err,
    output logic                      stp_err
);

    localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [PRESCALE_WIDTH-1:0] ONE      = PRESCALE_WIDTH'(1);
    localparam logic [BIT_CNT_W-1:0]      LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

    rx_state_t                 state;
    logic [PRESCALE_WIDTH-1:0] edge_cnt;
    logic [BIT_CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0]     shift_reg;
    logic [PRESCALE_WIDTH-1:0] prescale_lat;
    logic                      par_en_lat;
    logic                      par_typ_lat;
    logic                      par_flag;
    logic                      sampled_bit;
    logic                      sample_valid;
    logic                      bit_end;
    logic                      exp_parity;

    rx_data_sampler #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_sampler (
        .CLK          (CLK),
        .RST          (RST),
        .RX_IN        (RX_IN),
        .edge_cnt     (edge_cnt),
        .prescale     (prescale_lat),
        .sampled_bit  (sampled_bit),
        .sample_valid (sample_valid)
    );

    assign bit_end    = (edge_cnt == prescale_lat - ONE);
    assign exp_parity = (^shift_reg) ^ (par_typ_lat == PAR_ODD);

    // frame FSM, bit timing, deserializer and registered result strobes
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= ST_IDLE;
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            prescale_lat <= '0;
            par_en_lat   <= 1'b0;
            par_typ_lat  <= PAR_EVEN;
            par_flag     <= 1'b0;
            P_DATA       <= '0;
            Data_Valid   <= 1'b0;
            par_err      <= 1'b0;
            stp_err      <= 1'b0;
        end else begin
            Data_Valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            if (state == ST_IDLE) begin
                bit_cnt <= '0;
                if (!RX_IN) begin
                    // the detect edge is sample 0 of the start bit
                    state        <= ST_START;
                    edge_cnt     <= ONE;
                    prescale_lat <= Prescale;
                    par_en_lat   <= PAR_EN;
                    par_typ_lat  <= PAR_TYP;
                    par_flag     <= 1'b0;
                end else begin
                    edge_cnt <= '0;
                end
            end else if (bit_end) begin
                edge_cnt <= '0;
                if (sample_valid) begin
                    case (state)
                        ST_START: begin
                            state <= sampled_bit ? ST_IDLE : ST_DATA;
                        end
                        ST_DATA: begin
                            shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
                            bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
                            if (bit_cnt == LAST_BIT)
                                state <= par_en_lat ? ST_PARITY : ST_STOP;
                        end
                        ST_PARITY: begin
                            if (sampled_bit != exp_parity) par_flag <= 1'b1;
                            state <= ST_STOP;
                        end
                        ST_STOP: begin
                            state   <= ST_IDLE;
                            par_err <= par_flag;
                            stp_err <= ~sampled_bit;
                            if (!par_flag && sampled_bit) begin
                                P_DATA     <= shift_reg;
                                Data_Valid <= 1'b1;
                            end
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end else begin
                edge_cnt <= edge_cnt + ONE;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: good frames, parity/stop errors, glitches,
// back-to-back frames and reset in the middle of a frame.
module tb_uart_rx;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       par_err;
    logic       stp_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] dv_q[$];
    time        dv_time = 0;
    int         pe_cnt = 0;
    int         se_cnt = 0;
    int         long_cnt = 0;
    logic       prev_dv = 1'b0, prev_pe = 1'b0, prev_se = 1'b0;

    uart_rx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    always #5 CLK = ~CLK;

    // record strobes on the falling edge, away from the active edge
    always @(negedge CLK) begin
        if (Data_Valid) begin
            dv_q.push_back(P_DATA);
            dv_time = $time;
        end
        if (par_err) pe_cnt++;
        if (stp_err) se_cnt++;
        if ((Data_Valid && prev_dv) || (par_err && prev_pe) || (stp_err && prev_se))
            long_cnt++;
        prev_dv = Data_Valid;
        prev_pe = par_err;
        prev_se = stp_err;
    end

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // drive one bit value for n edges, optionally inverting a single edge
    task automatic drive_bit(input logic v, input int n, input int glitch_at, output time first_edge);
        first_edge = 0;
        for (int k = 0; k < n; k++) begin
            RX_IN = (k == glitch_at) ? ~v : v;
            @(posedge CLK);
            if (k == 0) first_edge = $time;
            #1;
        end
        RX_IN = v;
    endtask

    task automatic send_frame(input logic [7:0] d, input int p, input logic pen,
                              input logic pbit, input logic sbit, input int glitch_bit,
                              input bit scramble, output time t0);
        time dummy;
        drive_bit(1'b0, p, -1, t0);
        if (scramble) begin
            PAR_EN   = ~PAR_EN;
            PAR_TYP  = ~PAR_TYP;
            Prescale = 6'd8;
        end
        for (int i = 0; i < 8; i++)
            drive_bit(d[i], p, (i == glitch_bit) ? p / 2 : -1, dummy);
        if (pen) drive_bit(pbit, p, -1, dummy);
        drive_bit(sbit, p, -1, dummy);
        RX_IN = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd8;
        idle(3);
        checks++; if (P_DATA !== 8'h00) begin errors++; $display("FAIL reset_pdata: got %h expected 00", P_DATA); end
        checks++; if (Data_Valid !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b expected 0", Data_Valid); end
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL reset_par_err: got %b expected 0", par_err); end
        checks++; if (stp_err !== 1'b0) begin errors++; $display("FAIL reset_stp_err: got %b expected 0", stp_err); end
        RST = 1'b1;
        idle(4);
    endtask

    task automatic test_good_parity();
        int n0, pe0, se0;
        time t0;
        Prescale = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        n0 = dv_q.size(); pe0 = pe_cnt; se0 = se_cnt;
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, -1, 1'b0, t0);
        idle(3);
        checks++; if (dv_q.size() !== n0 + 1) begin errors++; $display("FAIL good_dv_count: got %0d expected %0d", dv_q.size() - n0, 1); end
        checks++; if (P_DATA !== 8'hA5) begin errors++; $display("FAIL good_pdata: got %h expected a5", P_DATA); end
        // stop end edge is detect + 87 clocks; strobe seen at the following falling edge
        checks++; if (dv_time !== t0 + 875) begin errors++; $display("FAIL good_timing: got %0t expected %0t", dv_time, t0 + 875); end
        checks++; if (pe_cnt !== pe0) begin errors++; $display("FAIL good_par_err: got %0d expected 0", pe_cnt - pe0); end
        checks++; if (se_cnt !== se0) begin errors++; $display("FAIL good_stp_err: got %0d expected 0", se_cnt - se0); end
        idle(4);
    endtask

    task automatic test_parity_error();
        int n0, pe0, se0;
        time t0;
        Prescale = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        n0 = dv_q.size(); pe0 = pe_cnt; se0 = se_cnt;
        send_frame(8'hA5, 8, 1'b1, 1'b1, 1'b1, -1, 1'b0, t0);
        idle(3);
        checks++; if (pe_cnt !== pe0 + 1) begin errors++; $display("FAIL perr_strobe: got %0d expected 1", pe_cnt - pe0); end
        checks++; if (dv_q.size() !== n0) begin errors++; $display("FAIL perr_dv: got %0d expected 0", dv_q.size() - n0); end
        checks++; if (se_cnt !== se0) begin errors++; $display("FAIL perr_stp_err: got %0d expected 0", se_cnt - se0); end
        checks++; if (P_DATA !== 8'hA5) begin errors++; $display("FAIL perr_pdata_hold: got %h expected a5", P_DATA); end
        idle(4);
    endtask

    // config pins are flipped right after the start bit; the latched values must rule
    task automatic test_stop_error();
        int n0, pe0, se0;
        time t0;
        Prescale = 6'd16; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        n0 = dv_q.size(); pe0 = pe_cnt; se0 = se_cnt;
        send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, -1, 1'b1, t0);
        idle(3);
        checks++; if (se_cnt !== se0 + 1) begin errors++; $display("FAIL serr_strobe: got %0d expected 1", se_cnt - se0); end
        checks++; if (dv_q.size() !== n0) begin errors++; $display("FAIL serr_dv: got %0d expected 0", dv_q.size() - n0); end
        checks++; if (pe_cnt !== pe0) begin errors++; $display("FAIL serr_par_err: got %0d expected 0", pe_cnt - pe0); end
        checks++; if (P_DATA !== 8'hA5) begin errors++; $display("FAIL serr_pdata_hold: got %h expected a5", P_DATA); end
        idle(4);
    endtask

    task automatic test_start_glitch();
        int n0, pe0, se0;
        time t0;
        Prescale = 6'd16; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        n0 = dv_q.size(); pe0 = pe_cnt; se0 = se_cnt;
        drive_bit(1'b0, 3, -1, t0);
        RX_IN = 1'b1;
        idle(40);
        checks++; if ((dv_q.size() !== n0) || (pe_cnt !== pe0) || (se_cnt !== se0)) begin
            errors++; $display("FAIL sglitch_no_strobe: got dv %0d pe %0d se %0d expected 0 0 0",
                               dv_q.size() - n0, pe_cnt - pe0, se_cnt - se0);
        end
        send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b1, -1, 1'b0, t0);
        idle(3);
        checks++; if (dv_q.size() !== n0 + 1) begin errors++; $display("FAIL sglitch_after_dv: got %0d expected 1", dv_q.size() - n0); end
        checks++; if (P_DATA !== 8'h3C) begin errors++; $display("FAIL sglitch_after_pdata: got %h expected 3c", P_DATA); end
        idle(4);
    endtask

    task automatic test_data_glitch();
        int n0, pe0;
        time t0;
        Prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b1;
        n0 = dv_q.size(); pe0 = pe_cnt;
        // 0x96 has four ones, so odd parity bit is 1; bit 2 is a 1 hit at mid-bit
        send_frame(8'h96, 16, 1'b1, 1'b1, 1'b1, 2, 1'b0, t0);
        idle(3);
        checks++; if (dv_q.size() !== n0 + 1) begin errors++; $display("FAIL dglitch_dv: got %0d expected 1", dv_q.size() - n0); end
        checks++; if (P_DATA !== 8'h96) begin errors++; $display("FAIL dglitch_pdata: got %h expected 96", P_DATA); end
        checks++; if (pe_cnt !== pe0) begin errors++; $display("FAIL dglitch_par_err: got %0d expected 0", pe_cnt - pe0); end
        idle(4);
    endtask

    task automatic test_back_to_back();
        int n0;
        time t0, t1;
        Prescale = 6'd32; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        n0 = dv_q.size();
        send_frame(8'h00, 32, 1'b0, 1'b0, 1'b1, -1, 1'b0, t0);
        send_frame(8'hFF, 32, 1'b0, 1'b0, 1'b1, -1, 1'b0, t1);
        idle(3);
        checks++; if (dv_q.size() !== n0 + 2) begin errors++; $display("FAIL b2b_dv_count: got %0d expected 2", dv_q.size() - n0); end
        if (dv_q.size() >= n0 + 2) begin
            checks++; if (dv_q[n0] !== 8'h00) begin errors++; $display("FAIL b2b_first: got %h expected 00", dv_q[n0]); end
            checks++; if (dv_q[n0+1] !== 8'hFF) begin errors++; $display("FAIL b2b_second: got %h expected ff", dv_q[n0+1]); end
        end
        checks++; if (dv_time !== t1 + 3195) begin errors++; $display("FAIL b2b_timing: got %0t expected %0t", dv_time, t1 + 3195); end
        idle(4);
    endtask

    task automatic test_reset_mid_frame();
        int n0, pe0, se0;
        time t0;
        logic [7:0] d;
        d = 8'h5A;
        Prescale = 6'd16; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        n0 = dv_q.size(); pe0 = pe_cnt; se0 = se_cnt;
        drive_bit(1'b0, 16, -1, t0);
        for (int i = 0; i < 4; i++) drive_bit(d[i], 16, -1, t0);
        drive_bit(d[4], 8, -1, t0);
        RST = 1'b0;
        #1;
        checks++; if (P_DATA !== 8'h00) begin errors++; $display("FAIL rmid_pdata: got %h expected 00", P_DATA); end
        checks++; if ({Data_Valid, par_err, stp_err} !== 3'b000) begin
            errors++; $display("FAIL rmid_strobes: got %b expected 000", {Data_Valid, par_err, stp_err});
        end
        RX_IN = 1'b1;
        idle(3);
        RST = 1'b1;
        idle(5);
        send_frame(8'h81, 16, 1'b0, 1'b0, 1'b1, -1, 1'b0, t0);
        idle(3);
        checks++; if (dv_q.size() !== n0 + 1) begin errors++; $display("FAIL rmid_dv_count: got %0d expected 1", dv_q.size() - n0); end
        checks++; if (P_DATA !== 8'h81) begin errors++; $display("FAIL rmid_after_pdata: got %h expected 81", P_DATA); end
        checks++; if ((pe_cnt !== pe0) || (se_cnt !== se0)) begin
            errors++; $display("FAIL rmid_errs: got pe %0d se %0d expected 0 0", pe_cnt - pe0, se_cnt - se0);
        end
        idle(4);
    endtask

    initial begin
        test_reset();
        test_good_parity();
        test_parity_error();
        test_stop_error();
        test_start_glitch();
        test_data_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        checks++; if (long_cnt !== 0) begin errors++; $display("FAIL strobe_width: got %0d long strobes expected 0", long_cnt); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
